// File: rtl/seven_seg_scanner.sv
// Time-multiplexes three decoded digits plus a minus sign onto one segment bus,
// with per-slot dead time and frame-synchronous snapshots. SEVEN_SEG_LZB_EN enables leading-zero blanking.
module seven_seg_scanner #(
   parameter int CLK_DIV       = 50000,
   parameter int BLANK_CYCLES  = 16,
   parameter int AN_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [6:0] seg_ones,
   input  logic [6:0] seg_tens,
   input  logic [6:0] seg_hundreds,
   input  logic       sign,
   input  logic       mode,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       frame_start
);

   localparam int          CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DRV  = CNT_W'(BLANK_CYCLES);
   localparam logic [3:0]  AN_OFF   = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic             run_q, run_d;
   logic [6:0]       snap_ones_q, snap_ones_d;
   logic [6:0]       snap_tens_q, snap_tens_d;
   logic [6:0]       snap_hund_q, snap_hund_d;
   logic             snap_sign_q, snap_sign_d;
   logic             snap_mode_q, snap_mode_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;
   logic             fs_q, fs_d;

   logic             take;
   logic [6:0]       blank_pat;
   logic [6:0]       minus_pat;
   logic [6:0]       digit_pat;
   logic             slot_blank;
   logic [3:0]       an_hot;

   // Next counter/snapshot state; outputs below are decoded from this next state
   // so the registered outputs line up with cnt/idx after each edge.
   always_comb begin
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      run_d       = run_q;
      take        = 1'b0;
      if (!en) begin
         cnt_d = '0;
         idx_d = 2'd0;
         run_d = 1'b0;
      end else if (!run_q) begin
         run_d = 1'b1;
         take  = 1'b1;
         cnt_d = '0;
         idx_d = 2'd0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
         take  = (idx_q == 2'd3);
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      snap_ones_d = take ? seg_ones     : snap_ones_q;
      snap_tens_d = take ? seg_tens     : snap_tens_q;
      snap_hund_d = take ? seg_hundreds : snap_hund_q;
      snap_sign_d = take ? sign         : snap_sign_q;
      snap_mode_d = take ? mode         : snap_mode_q;
      fs_d        = take;
   end

   always_comb begin
      blank_pat = snap_mode_d ? 7'h7F : 7'h00;
      minus_pat = snap_mode_d ? 7'b0111111 : 7'b1000000;
      an_hot    = 4'b0001 << idx_d;
      case (idx_d)
         2'd0:    digit_pat = snap_ones_d;
         2'd1:    digit_pat = snap_tens_d;
         2'd2:    digit_pat = snap_hund_d;
         default: digit_pat = snap_sign_d ? minus_pat : blank_pat;
      endcase
`ifdef SEVEN_SEG_LZB_EN
      begin
         logic [6:0] zero_pat;
         logic       hund_zero;
         zero_pat   = snap_mode_d ? 7'b1000000 : 7'b0111111;
         hund_zero  = (snap_hund_d == zero_pat);
         slot_blank = ((idx_d == 2'd2) && hund_zero) ||
                      ((idx_d == 2'd1) && hund_zero && (snap_tens_d == zero_pat));
      end
`else
      slot_blank = 1'b0;
`endif
      if (!en) begin
         seg_d = mode ? 7'h7F : 7'h00;
         an_d  = AN_OFF;
      end else if ((cnt_d < CNT_DRV) || slot_blank) begin
         seg_d = blank_pat;
         an_d  = AN_OFF;
      end else begin
         seg_d = digit_pat;
         an_d  = (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         idx_q       <= 2'd0;
         run_q       <= 1'b0;
         snap_ones_q <= 7'h00;
         snap_tens_q <= 7'h00;
         snap_hund_q <= 7'h00;
         snap_sign_q <= 1'b0;
         snap_mode_q <= 1'b0;
         seg_q       <= 7'h00;
         an_q        <= AN_OFF;
         fs_q        <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         run_q       <= run_d;
         snap_ones_q <= snap_ones_d;
         snap_tens_q <= snap_tens_d;
         snap_hund_q <= snap_hund_d;
         snap_sign_q <= snap_sign_d;
         snap_mode_q <= snap_mode_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
         fs_q        <= fs_d;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with CLK_DIV=8, BLANK_CYCLES=2, active-low an.
module tb_seven_seg_scanner;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [6:0] seg_ones, seg_tens, seg_hundreds;
   logic       sign, mode;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame_start;

   int checks   = 0;
   int failures = 0;

   seven_seg_scanner #(.CLK_DIV(8), .BLANK_CYCLES(2), .AN_ACTIVE_LOW(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .seg_ones     (seg_ones),
      .seg_tens     (seg_tens),
      .seg_hundreds (seg_hundreds),
      .sign         (sign),
      .mode         (mode),
      .seg          (seg),
      .an           (an),
      .frame_start  (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Walks one 32-cycle frame starting at its cnt=0 cycle; eseg/ean hold slot 3..0 values.
   task automatic check_frame(input string tag, input logic [27:0] eseg,
                              input logic [15:0] ean, input logic [6:0] bseg);
      int err0;
      err0 = failures;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 8; c++) begin
            chk($sformatf("%s_s%0d_c%0d_fs", tag, s, c), 32'(frame_start),
                32'((s == 0 && c == 0) ? 1 : 0));
            if (c < 2) begin
               chk($sformatf("%s_s%0d_c%0d_an", tag, s, c), 32'(an), 32'h0000000F);
               chk($sformatf("%s_s%0d_c%0d_seg", tag, s, c), 32'(seg), 32'(bseg));
            end else begin
               chk($sformatf("%s_s%0d_c%0d_an", tag, s, c), 32'(an), 32'(ean[s*4 +: 4]));
               chk($sformatf("%s_s%0d_c%0d_seg", tag, s, c), 32'(seg), 32'(eseg[s*7 +: 7]));
            end
            @(negedge clk);
         end
      end
      $display("frame %s: %s", tag, (failures == err0) ? "ok" : "errors");
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; sign = 1'b1; mode = 1'b0;
      seg_ones = 7'h06; seg_tens = 7'h5B; seg_hundreds = 7'h4F;
      repeat (3) @(negedge clk);
      chk("reset_an", 32'(an), 32'hF);
      chk("reset_seg", 32'(seg), 32'h00);
      chk("reset_fs", 32'(frame_start), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Normal frame, then change inputs at frame start: next frame still old.
      check_frame("f1", {7'h40, 7'h4F, 7'h5B, 7'h06}, 16'h7BDE, 7'h00);
      mode = 1'b1; sign = 1'b0;
      seg_ones = 7'h79; seg_tens = 7'h24; seg_hundreds = 7'h30;
      check_frame("f2_old", {7'h40, 7'h4F, 7'h5B, 7'h06}, 16'h7BDE, 7'h00);
      check_frame("f3_mode1", {7'h7F, 7'h30, 7'h24, 7'h79}, 16'h7BDE, 7'h7F);

      // Mid-slot-1 change of tens must not tear the current frame.
      fork
         begin
            repeat (12) @(negedge clk);
            seg_tens = 7'h12;
         end
      join_none
      check_frame("f4_tear", {7'h7F, 7'h30, 7'h24, 7'h79}, 16'h7BDE, 7'h7F);
      check_frame("f5_new", {7'h7F, 7'h30, 7'h12, 7'h79}, 16'h7BDE, 7'h7F);

      // Drop en during idx=2 drive.
      repeat (20) @(negedge clk);
      chk("pre_endrop_an", 32'(an), 32'hB);
      en = 1'b0; mode = 1'b0; sign = 1'b1;
      seg_ones = 7'h06; seg_tens = 7'h5B; seg_hundreds = 7'h4F;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("en0_%0d_an", i), 32'(an), 32'hF);
         chk($sformatf("en0_%0d_seg", i), 32'(seg), 32'h00);
         chk($sformatf("en0_%0d_fs", i), 32'(frame_start), 32'h0);
      end
      en = 1'b1;
      @(negedge clk);
      check_frame("f6_reen", {7'h40, 7'h4F, 7'h5B, 7'h06}, 16'h7BDE, 7'h00);

      // Short async reset pulse in mid-drive of slot 1.
      repeat (10) @(negedge clk);
      chk("pre_rst_an", 32'(an), 32'hD);
      #1 rst = 1'b1;
      #2;
      chk("async_rst_an", 32'(an), 32'hF);
      chk("async_rst_seg", 32'(seg), 32'h00);
      #1 rst = 1'b0;
      @(negedge clk);
      sign = 1'b0;
      seg_ones = 7'h06; seg_tens = 7'h3F; seg_hundreds = 7'h3F;
      check_frame("f7_restart", {7'h40, 7'h4F, 7'h5B, 7'h06}, 16'h7BDE, 7'h00);
      seg_hundreds = 7'h06;
`ifdef SEVEN_SEG_LZB_EN
      check_frame("f8_lzb", {7'h00, 7'h00, 7'h00, 7'h06}, 16'h7FFE, 7'h00);
`else
      check_frame("f8_nolzb", {7'h00, 7'h3F, 7'h3F, 7'h06}, 16'h7BDE, 7'h00);
`endif
      // Nonzero hundreds: the zero tens digit stays visible either way.
      check_frame("f9_tens0", {7'h00, 7'h06, 7'h3F, 7'h06}, 16'h7BDE, 7'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
